// File: rtl/ldce_write_seq.sv
// Write sequencer for a bank of gated D-latches: registered data setup, gate pulse,
// data hold and clear-all, driven from a valid/ready command port.
module ldce_write_seq #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AW        = 2,
  parameter int SETUP_CYC = 1,
  parameter int GATE_CYC  = 2,
  parameter int HOLD_CYC  = 1,
  parameter int CLR_CYC   = 1
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_CLEAR,
  input  logic [AW-1:0]    REQ_ADDR,
  input  logic [WIDTH-1:0] REQ_DATA,
  output logic [WIDTH-1:0] LAT_D,
  output logic [DEPTH-1:0] LAT_G,
  output logic             LAT_GE,
  output logic             LAT_CLR,
  output logic             DONE,
  output logic             ERR
);

  // state  | meaning
  // IDLE   | ready for a command; DONE/ERR pulse here on return
  // SETUP  | LAT_D driven with new data, gate still closed
  // GATE   | selected G line and GE open
  // HOLD   | gate closed, LAT_D held
  // CLEAR  | LAT_CLR asserted to the whole bank

  localparam int MAX_AB = (SETUP_CYC > GATE_CYC) ? SETUP_CYC : GATE_CYC;
  localparam int MAX_CD = (HOLD_CYC > CLR_CYC) ? HOLD_CYC : CLR_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW = $clog2(MAX_CYC + 1);

  if (WIDTH < 1 || DEPTH < 1 || AW < 1 || (1 << AW) < DEPTH ||
      SETUP_CYC < 1 || GATE_CYC < 1 || HOLD_CYC < 1 || CLR_CYC < 1) begin : g_param_check
    $error("ldce_write_seq: illegal parameter set");
  end

  localparam logic [AW:0]   DEPTH_V  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_GATE  = CW'(GATE_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_CLR   = CW'(CLR_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_GATE  = 3'd2,
    S_HOLD  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t            state, nxt_state;
  logic [CW-1:0]     cnt, nxt_cnt;
  logic [AW-1:0]     addr_q, nxt_addr;
  logic [WIDTH-1:0]  nxt_d;
  logic [DEPTH-1:0]  addr_dec, nxt_g;
  logic              addr_bad;
  logic              accept;
  logic              lat_clr_q;
  logic              nxt_ge, nxt_clr, nxt_done, nxt_err, nxt_ready;

  always_comb begin
    addr_dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      addr_dec[i] = (addr_q == AW'(i));
    end
  end

  assign addr_bad = ({1'b0, addr_q} >= DEPTH_V);
  assign accept   = REQ_VALID & REQ_READY;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_addr  = addr_q;
    nxt_d     = LAT_D;
    nxt_done  = 1'b0;
    nxt_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (REQ_CLEAR) begin
            nxt_state = S_CLEAR;
            nxt_cnt   = LD_CLR;
          end else begin
            nxt_state = S_SETUP;
            nxt_cnt   = LD_SETUP;
            nxt_addr  = REQ_ADDR;
            nxt_d     = REQ_DATA;
          end
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          nxt_state = S_GATE;
          nxt_cnt   = LD_GATE;
        end else begin
          nxt_cnt = cnt - 1'b1;
        end
      end
      S_GATE: begin
        if (cnt == '0) begin
          nxt_state = S_HOLD;
          nxt_cnt   = LD_HOLD;
        end else begin
          nxt_cnt = cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          nxt_state = S_IDLE;
          nxt_done  = 1'b1;
          nxt_err   = addr_bad;
        end else begin
          nxt_cnt = cnt - 1'b1;
        end
      end
      S_CLEAR: begin
        if (cnt == '0) begin
          nxt_state = S_IDLE;
          nxt_done  = 1'b1;
        end else begin
          nxt_cnt = cnt - 1'b1;
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and then registered, so every latch
  // control comes straight off a flop. addr_q is stable from SETUP onward.
  always_comb begin
    nxt_ge    = (nxt_state == S_GATE);
    nxt_g     = nxt_ge ? addr_dec : '0;
    nxt_clr   = (nxt_state == S_CLEAR);
    nxt_ready = (nxt_state == S_IDLE);
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      LAT_D     <= '0;
      LAT_G     <= '0;
      LAT_GE    <= 1'b0;
      lat_clr_q <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      REQ_READY <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      addr_q    <= nxt_addr;
      LAT_D     <= nxt_d;
      LAT_G     <= nxt_g;
      LAT_GE    <= nxt_ge;
      lat_clr_q <= nxt_clr;
      DONE      <= nxt_done;
      ERR       <= nxt_err;
      REQ_READY <= nxt_ready;
    end
  end

  // Reset clears the bank directly, without waiting for a clock.
  assign LAT_CLR = CLR | lat_clr_q;

endmodule

// File: tb/tb_ldce_write_seq.sv
// Bench for ldce_write_seq: three parameterisations, hand sequences, a vector table,
// and a randomized run against a phase-offset reference model.
module tb_ldce_write_seq;

  localparam int S0 = 1, G0 = 2, H0 = 1, CC0 = 1;

  logic C = 1'b0;
  logic CLR = 1'b0;
  always #5 C = ~C;

  logic       v0, c0, r0, ge0, lc0, dn0, er0;
  logic [1:0] a0;
  logic [7:0] d0, ld0;
  logic [3:0] g0;

  logic       v1, c1, r1, ge1, lc1, dn1, er1;
  logic [1:0] a1;
  logic [7:0] d1, ld1;
  logic [3:0] g1;

  logic       v2, c2, r2, ge2, lc2, dn2, er2;
  logic [1:0] a2;
  logic [7:0] d2, ld2;
  logic [2:0] g2;

  ldce_write_seq #(.WIDTH(8), .DEPTH(4), .AW(2), .SETUP_CYC(S0), .GATE_CYC(G0),
                   .HOLD_CYC(H0), .CLR_CYC(CC0)) dut0 (
    .C(C), .CLR(CLR), .REQ_VALID(v0), .REQ_READY(r0), .REQ_CLEAR(c0), .REQ_ADDR(a0),
    .REQ_DATA(d0), .LAT_D(ld0), .LAT_G(g0), .LAT_GE(ge0), .LAT_CLR(lc0), .DONE(dn0), .ERR(er0));

  ldce_write_seq #(.WIDTH(8), .DEPTH(4), .AW(2), .CLR_CYC(3)) dut1 (
    .C(C), .CLR(CLR), .REQ_VALID(v1), .REQ_READY(r1), .REQ_CLEAR(c1), .REQ_ADDR(a1),
    .REQ_DATA(d1), .LAT_D(ld1), .LAT_G(g1), .LAT_GE(ge1), .LAT_CLR(lc1), .DONE(dn1), .ERR(er1));

  ldce_write_seq #(.WIDTH(8), .DEPTH(3), .AW(2)) dut2 (
    .C(C), .CLR(CLR), .REQ_VALID(v2), .REQ_READY(r2), .REQ_CLEAR(c2), .REQ_ADDR(a2),
    .REQ_DATA(d2), .LAT_D(ld2), .LAT_G(g2), .LAT_GE(ge2), .LAT_CLR(lc2), .DONE(dn2), .ERR(er2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  typedef struct {
    logic       clr;
    logic [1:0] addr;
    logic [7:0] data;
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    int         exp_lat;
  } vec_t;

  vec_t vt[6];

  logic [3:0] gh[10];
  logic       dnh[10];
  logic [7:0] dh[10];

  // reference model state for dut0
  bit         m_busy, m_clr, m_ready, m_done, m_err;
  logic [1:0] m_addr;
  logic [7:0] m_d;
  int         m_t;

  task automatic model_edge();
    m_done = 1'b0;
    m_err  = 1'b0;
    if (m_busy) begin
      m_t++;
      if (m_t == (m_clr ? CC0 : S0 + G0 + H0)) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_err  = !m_clr && (m_addr >= 2'd3) && (int'(m_addr) >= 4);
      end
    end else if (m_ready && v0) begin
      m_busy = 1'b1;
      m_clr  = c0;
      m_t    = 0;
      if (!c0) begin
        m_addr = a0;
        m_d    = d0;
      end
    end
    m_ready = !m_busy;
  endtask

  initial begin
    int n, lat, first_b, last_a;
    logic [3:0] gor;
    logic clr_seen, multi_g;
    logic exp_ge, exp_lc;
    logic [3:0] exp_g;

    v0 = 0; c0 = 0; a0 = 0; d0 = 0;
    v1 = 0; c1 = 0; a1 = 0; d1 = 0;
    v2 = 0; c2 = 0; a2 = 0; d2 = 0;

    // reset takes effect before any clock edge
    #1 CLR = 1'b1;
    #2;
    chk("rst_g", g0, 0);
    chk("rst_ge", ge0, 0);
    chk("rst_d", ld0, 0);
    chk("rst_latclr", lc0, 1);
    chk("rst_ready", r0, 0);
    repeat (2) @(posedge C);
    @(negedge C) CLR = 1'b0;
    #1 chk("rel_ready_pre_edge", r0, 0);
    step();
    chk("rel_ready", r0, 1);
    chk("rel_latclr", lc0, 0);

    // single write, addr 2, data A5
    @(negedge C);
    v0 = 1; c0 = 0; a0 = 2; d0 = 8'hA5;
    step();
    chk("wr_e0_d", ld0, 8'hA5);
    chk("wr_e0_g", g0, 0);
    chk("wr_e0_ready", r0, 0);
    v0 = 0;
    step();
    chk("wr_e1_g", g0, 4'b0100);
    chk("wr_e1_ge", ge0, 1);
    step();
    chk("wr_e2_g", g0, 4'b0100);
    chk("wr_e2_ge", ge0, 1);
    step();
    chk("wr_e3_g", g0, 0);
    chk("wr_e3_ge", ge0, 0);
    chk("wr_e3_d", ld0, 8'hA5);
    chk("wr_e3_done", dn0, 0);
    step();
    chk("wr_e4_done", dn0, 1);
    chk("wr_e4_ready", r0, 1);
    chk("wr_e4_err", er0, 0);
    step();
    chk("wr_e5_done", dn0, 0);
    chk("wr_e5_d", ld0, 8'hA5);

    // back-to-back writes with VALID held
    v0 = 1; a0 = 1; d0 = 8'h11;
    step();
    chk("b2b_e0_d", ld0, 8'h11);
    a0 = 3; d0 = 8'h33;
    for (int k = 1; k < 10; k++) begin
      step();
      gh[k] = g0; dnh[k] = dn0; dh[k] = ld0;
      if (k == 5) v0 = 0;
    end
    chk("b2b_g1", gh[1], 4'b0010);
    chk("b2b_g2", gh[2], 4'b0010);
    chk("b2b_done1", dnh[4], 1);
    chk("b2b_d_before", dh[4], 8'h11);
    chk("b2b_accept_on_done", dh[5], 8'h33);
    chk("b2b_g6", gh[6], 4'b1000);
    chk("b2b_g7", gh[7], 4'b1000);
    chk("b2b_done2", dnh[9], 1);
    last_a = -1; first_b = -1;
    for (int k = 1; k < 10; k++) begin
      if (gh[k] == 4'b0010) last_a = k;
      if (gh[k] == 4'b1000 && first_b < 0) first_b = k;
    end
    chk("b2b_gap", 32'((first_b - last_a - 1) >= 2 && last_a > 0), 1);

    // clear with CLR_CYC=3 on dut1, after a write
    v1 = 1; c1 = 0; a1 = 1; d1 = 8'h5A;
    step();
    v1 = 0;
    repeat (4) step();
    chk("clr_pre_done", dn1, 1);
    v1 = 1; c1 = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) begin v1 = 0; c1 = 0; end
      chk($sformatf("clr3_latclr_%0d", k), lc1, 32'(k < 3));
      chk($sformatf("clr3_g_%0d", k), g1, 0);
      chk($sformatf("clr3_done_%0d", k), dn1, 32'(k == 3));
    end
    chk("clr3_d_kept", ld1, 8'h5A);

    // DEPTH=3, out-of-range write
    v2 = 1; c2 = 0; a2 = 3; d2 = 8'h77;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 0) v2 = 0;
      chk($sformatf("oor_g_%0d", k), g2, 0);
      chk($sformatf("oor_ge_%0d", k), ge2, 32'(k == 1 || k == 2));
      chk($sformatf("oor_done_%0d", k), dn2, 32'(k == 4));
      chk($sformatf("oor_err_%0d", k), er2, 32'(k == 4));
    end

    // reset in the middle of a gate pulse
    v0 = 1; c0 = 0; a0 = 1; d0 = 8'hC3;
    step();
    v0 = 0;
    step();
    chk("abort_gate_open", g0, 4'b0010);
    #2 CLR = 1'b1;
    #1;
    chk("abort_g", g0, 0);
    chk("abort_ge", ge0, 0);
    chk("abort_done", dn0, 0);
    chk("abort_latclr", lc0, 1);
    n = 0;
    repeat (3) begin
      @(posedge C); #1;
      if (dn0 !== 1'b0) n++;
    end
    chk("abort_no_done", n, 0);
    @(negedge C) CLR = 1'b0;
    step();
    chk("abort_ready", r0, 1);

    // command table on dut0 (first entry is the post-abort write to addr 0)
    vt[0] = '{1'b0, 2'd0, 8'h3C, 4'b0001, 8'h3C, 4};
    vt[1] = '{1'b0, 2'd3, 8'h96, 4'b1000, 8'h96, 4};
    vt[2] = '{1'b1, 2'd0, 8'h00, 4'b0000, 8'h96, 1};
    vt[3] = '{1'b0, 2'd2, 8'h01, 4'b0100, 8'h01, 4};
    vt[4] = '{1'b1, 2'd3, 8'hFF, 4'b0000, 8'h01, 1};
    vt[5] = '{1'b0, 2'd1, 8'hFE, 4'b0010, 8'hFE, 4};
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (r0 !== 1'b1 && n < 20) begin step(); n++; end
      chk($sformatf("vec%0d_ready_wait", i), 32'(n < 20), 1);
      v0 = 1; c0 = vt[i].clr; a0 = vt[i].addr; d0 = vt[i].data;
      step();
      v0 = 0;
      gor = g0; clr_seen = lc0; multi_g = 1'b0; lat = 0;
      while (dn0 !== 1'b1 && lat < 20) begin
        step();
        lat++;
        gor = gor | g0;
        clr_seen = clr_seen | lc0;
        if ($countones(g0) > 1) multi_g = 1'b1;
      end
      chk($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
      chk($sformatf("vec%0d_gate", i), gor, vt[i].exp_g);
      chk($sformatf("vec%0d_data", i), ld0, vt[i].exp_d);
      chk($sformatf("vec%0d_latclr", i), clr_seen, vt[i].clr);
      chk($sformatf("vec%0d_err", i), er0, 0);
      chk($sformatf("vec%0d_onehot", i), multi_g, 0);
    end

    // randomized run against the reference model
    @(negedge C) CLR = 1'b1;
    v0 = 0;
    m_busy = 0; m_ready = 0; m_d = 0; m_t = 0; m_clr = 0; m_addr = 0;
    m_done = 0; m_err = 0;
    repeat (2) @(posedge C);
    @(negedge C) CLR = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      v0 = ($urandom_range(0, 2) != 0);
      c0 = ($urandom_range(0, 4) == 0);
      a0 = 2'($urandom_range(0, 3));
      d0 = 8'($urandom);
      @(posedge C);
      model_edge();
      #1;
      exp_ge = m_busy && !m_clr && (m_t >= S0) && (m_t < S0 + G0);
      exp_g  = exp_ge ? (4'b0001 << m_addr) : 4'b0000;
      exp_lc = m_busy && m_clr;
      chk("rnd_ready", r0, m_ready);
      chk("rnd_d", ld0, m_d);
      chk("rnd_g", g0, exp_g);
      chk("rnd_ge", ge0, exp_ge);
      chk("rnd_latclr", lc0, exp_lc);
      chk("rnd_done", dn0, m_done);
      chk("rnd_err", er0, m_err);
      chk("rnd_no_overlap", (|g0) & lc0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
